// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through cache with true-LRU replacement, optional
// write-allocate, single-cycle flush and saturating hit/miss counters.
module set_assoc_cache #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SETS        = 64,
    parameter int WAYS        = 2,
    parameter int WORDS       = 8,
    parameter int WRITE_ALLOC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_DATA, WRITE_MEM} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAY_W-1:0]    victim_q;
    logic [OFF_W-1:0]    cnt_q;
    logic                first_q;
    logic                rsp_hit_q;
    logic [15:0]         hit_cnt_q, miss_cnt_q;

    logic [WAYS-1:0]              valid_q [SETS];
    logic [TAG_W-1:0]             tag_q   [SETS][WAYS];
    logic [WAY_W-1:0]             age_q   [SETS][WAYS];
    logic [DATA_W-1:0]            data_q  [SETS][WAYS][WORDS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [OFF_W-1:0] off;
    assign idx = addr_q[OFF_W+IDX_W:OFF_W+1];
    assign tag = addr_q[ADDR_W-1:ADDR_W-TAG_W];
    assign off = addr_q[OFF_W:1];

    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, victim;

    // Victim: lowest invalid way, otherwise the oldest (age WAYS-1).
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++)
                if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
    end

    logic do_flush, accept, upd_lru, wr_hit, set_victim, fill_beat, fill_last;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        do_flush   = 1'b0;
        accept     = 1'b0;
        upd_lru    = 1'b0;
        wr_hit     = 1'b0;
        set_victim = 1'b0;
        fill_beat  = 1'b0;
        fill_last  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ~flush;
                if (flush) begin
                    do_flush = 1'b1;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    upd_lru = 1'b1;
                    if (write_q) begin
                        wr_hit  = 1'b1;
                        state_d = WRITE_MEM;
                    end else begin
                        rsp_valid = 1'b1;
                        rsp_rdata = data_q[idx][hit_way][off];
                        state_d   = IDLE;
                    end
                end else if (!write_q || WRITE_ALLOC != 0) begin
                    set_victim = 1'b1;
                    state_d    = FILL_REQ;
                end else begin
                    state_d = WRITE_MEM;
                end
            end
            FILL_REQ: begin
                mem_rd_req = 1'b1;
                mem_addr   = {addr_q[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
                if (mem_ack) state_d = FILL_DATA;
            end
            FILL_DATA: begin
                if (mem_rdata_valid) begin
                    fill_beat = 1'b1;
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        fill_last = 1'b1;
                        state_d   = LOOKUP;
                    end
                end
            end
            WRITE_MEM: begin
                mem_wr_req = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                if (mem_ack) begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first lookup's outcome is visible in the same cycle as a read-hit response.
    assign rsp_hit  = (state_q == LOOKUP && first_q) ? hit : rsp_hit_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            victim_q   <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            rsp_hit_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
                first_q <= 1'b1;
            end
            if (state_q == LOOKUP) begin
                first_q <= 1'b0;
                if (first_q) begin
                    rsp_hit_q <= hit;
                    if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
                    if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
            if (set_victim) victim_q <= victim;
            if (state_q == FILL_REQ && mem_ack) cnt_q <= '0;
            else if (fill_beat)                 cnt_q <= cnt_q + 1'b1;
        end
    end

    // A line being refilled is invalid until its last beat lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else if (do_flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            if (set_victim) valid_q[idx][victim] <= 1'b0;
            if (fill_last)  valid_q[idx][victim_q] <= 1'b1;
            if (upd_lru) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < age_q[idx][hit_way])
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit)    data_q[idx][hit_way][off]    <= wdata_q;
        if (fill_beat) data_q[idx][victim_q][cnt_q] <= mem_rdata;
        if (fill_last) tag_q[idx][victim_q]         <= tag;
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: dut0 is no-write-allocate, dut1 write-allocate,
// each with its own memory responder and response monitor.
module tb_set_assoc_cache;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]       flush, req_valid, req_write, req_ready, rsp_valid, rsp_hit;
    logic [1:0]       mem_rd_req, mem_wr_req, mem_ack, mem_rdata_valid;
    logic [1:0][15:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0][15:0] hit_cnt, miss_cnt;

    set_assoc_cache #(.WRITE_ALLOC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]), .req_valid(req_valid[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_hit(rsp_hit[0]), .mem_rd_req(mem_rd_req[0]), .mem_wr_req(mem_wr_req[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]),
        .mem_rdata_valid(mem_rdata_valid[0]), .mem_rdata(mem_rdata[0]),
        .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0]));

    set_assoc_cache #(.WRITE_ALLOC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]), .req_valid(req_valid[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_hit(rsp_hit[1]), .mem_rd_req(mem_rd_req[1]), .mem_wr_req(mem_wr_req[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]),
        .mem_rdata_valid(mem_rdata_valid[1]), .mem_rdata(mem_rdata[1]),
        .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1]));

    typedef struct {
        logic [15:0] rdata;
        logic        hit;
        int          lat;
        time         t0;
    } exp_t;

    exp_t        sb0[$], sb1[$];
    logic [15:0] mem [2][32768];
    int          checks = 0, errors = 0;
    int          rd_cnt[2], wr_cnt[2], beat_cnt[2], rsp_cnt[2], stray[2];
    logic [15:0] last_rd_addr[2], last_wr_addr[2], last_wr_data[2];

    localparam logic [127:0] RST_OUT = 128'h1 << 84;

    function automatic logic [127:0] outv(input int d);
        return {43'd0, req_ready[d], rsp_valid[d], rsp_hit[d], mem_rd_req[d], mem_wr_req[d],
                rsp_rdata[d], mem_addr[d], mem_wdata[d], hit_cnt[d], miss_cnt[d]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic monitor(input int d);
        exp_t e;
        bit   got;
        forever begin
            @(negedge clk);
            #1;
            if (mem_rd_req[d] && mem_wr_req[d]) begin
                checks++;
                errors++;
                $display("FAIL rd_wr_overlap dut%0d both requests high", d);
            end
            if (rsp_valid[d]) begin
                got = 0;
                if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); got = 1; end
                if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); got = 1; end
                if (!got) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d rdata=%h expected no response", d, rsp_rdata[d]);
                end else begin
                    chk($sformatf("rsp_rdata dut%0d", d), rsp_rdata[d], e.rdata);
                    chk($sformatf("rsp_hit dut%0d", d), rsp_hit[d], e.hit);
                    if (e.lat > 0) chk($sformatf("rsp_latency dut%0d", d), ($time - e.t0) / 10, e.lat);
                end
                rsp_cnt[d]++;
            end
        end
    endtask

    // Memory model: ack two cycles after a request appears, then 8 beats for reads.
    task automatic responder(input int d);
        logic [15:0] a, wd;
        forever begin
            @(negedge clk);
            mem_ack[d] = 1'b0;
            mem_rdata_valid[d] = 1'b0;
            if (!rst_n) continue;
            if (stray[d] > 0) begin
                mem_rdata_valid[d] = 1'b1;
                mem_rdata[d] = 16'hDEAD;
                stray[d]--;
            end else if (mem_rd_req[d]) begin
                a = mem_addr[d];
                repeat (2) begin
                    @(negedge clk);
                    chk($sformatf("rd_hold dut%0d", d), {mem_rd_req[d], mem_addr[d]}, {1'b1, a});
                end
                mem_ack[d] = 1'b1;
                rd_cnt[d]++;
                last_rd_addr[d] = a;
                @(negedge clk);
                mem_ack[d] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    mem_rdata_valid[d] = 1'b1;
                    mem_rdata[d] = mem[d][int'(a >> 1) + i];
                    beat_cnt[d]++;
                    @(negedge clk);
                    if (!rst_n) break;
                end
                mem_rdata_valid[d] = 1'b0;
            end else if (mem_wr_req[d]) begin
                a  = mem_addr[d];
                wd = mem_wdata[d];
                repeat (2) begin
                    @(negedge clk);
                    chk($sformatf("wr_hold dut%0d", d), {mem_wr_req[d], mem_addr[d], mem_wdata[d]}, {1'b1, a, wd});
                end
                mem_ack[d] = 1'b1;
                wr_cnt[d]++;
                last_wr_addr[d] = a;
                last_wr_data[d] = wd;
                mem[d][int'(a >> 1)] = wd;
                @(negedge clk);
                mem_ack[d] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int d, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input bit exp_hit, input int lat, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        flush[d]     = 1'b0;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        #1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout dut%0d addr=%h", d, addr);
            req_valid[d] = 1'b0;
            return;
        end
        e.rdata = exp_rd; e.hit = exp_hit; e.lat = lat; e.t0 = $time;
        if (push) begin
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input int target);
        int n = 0;
        while (rsp_cnt[d] < target && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (rsp_cnt[d] < target) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut%0d got=%0d expected=%0d", d, rsp_cnt[d], target);
        end
    endtask

    task automatic do_req(input int d, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input bit exp_hit, input int lat);
        int target = rsp_cnt[d] + 1;
        issue(d, wr, addr, wd, exp_rd, exp_hit, lat, 1'b1);
        wait_rsp(d, target);
    endtask

    initial responder(0);
    initial responder(1);
    initial monitor(0);
    initial monitor(1);

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, w0, b0, n, target;
        rst_n = 1'b0;
        flush = '0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_ack = '0; mem_rdata_valid = '0; mem_rdata = '0;
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 0; wr_cnt[d] = 0; beat_cnt[d] = 0; rsp_cnt[d] = 0; stray[d] = 0;
            last_rd_addr[d] = '0; last_wr_addr[d] = '0; last_wr_data[d] = '0;
            for (int i = 0; i < 32768; i++) mem[d][i] = 16'(i);
            for (int i = 0; i < 8; i++) mem[d][16'h918 + i] = 16'h1000 + 16'(i);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state dut0", outv(0), RST_OUT);
        chk("reset_state dut1", outv(1), RST_OUT);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read, then reread hit with 1-cycle latency.
        do_req(0, 0, 16'h1234, 16'h0, 16'h1002, 1'b0, 0);
        chk("fill_addr", last_rd_addr[0], 16'h1230);
        chk("miss_cnt_cold", miss_cnt[0], 16'd1);
        do_req(0, 0, 16'h1234, 16'h0, 16'h1002, 1'b1, 1);
        chk("hit_cnt_reread", hit_cnt[0], 16'd1);

        // LRU eviction within set 1.
        r0 = rd_cnt[0];
        do_req(0, 0, 16'h0010, 16'h0, 16'h0008, 1'b0, 0);
        do_req(0, 0, 16'h0410, 16'h0, 16'h0208, 1'b0, 0);
        do_req(0, 0, 16'h0010, 16'h0, 16'h0008, 1'b1, 1);
        do_req(0, 0, 16'h0810, 16'h0, 16'h0408, 1'b0, 0);
        do_req(0, 0, 16'h0010, 16'h0, 16'h0008, 1'b1, 1);
        do_req(0, 0, 16'h0410, 16'h0, 16'h0208, 1'b0, 0);
        chk("lru_fill_count", rd_cnt[0] - r0, 4);
        chk("lru_last_fill", last_rd_addr[0], 16'h0410);

        // No-write-allocate store miss.
        r0 = rd_cnt[0]; w0 = wr_cnt[0];
        do_req(0, 1, 16'h2002, 16'hBEEF, 16'h0, 1'b0, 0);
        chk("nwa_wr_count", wr_cnt[0] - w0, 1);
        chk("nwa_no_fill", rd_cnt[0] - r0, 0);
        chk("nwa_wr_addr_data", {last_wr_addr[0], last_wr_data[0]}, {16'h2002, 16'hBEEF});
        do_req(0, 0, 16'h2002, 16'h0, 16'hBEEF, 1'b0, 0);
        chk("counts_dut0", {hit_cnt[0], miss_cnt[0]}, {16'd3, 16'd7});

        // Write-allocate store miss: fill, then write-through.
        do_req(1, 1, 16'h2002, 16'hBEEF, 16'h0, 1'b0, 0);
        chk("wa_fill_addr", last_rd_addr[1], 16'h2000);
        chk("wa_wr", {16'(wr_cnt[1]), last_wr_addr[1], last_wr_data[1]}, {16'd1, 16'h2002, 16'hBEEF});
        do_req(1, 0, 16'h2002, 16'h0, 16'hBEEF, 1'b1, 1);
        chk("counts_dut1", {hit_cnt[1], miss_cnt[1]}, {16'd1, 16'd1});

        // Flush and request in the same cycle: flush wins.
        target = rsp_cnt[0] + 1;
        @(negedge clk);
        flush[0] = 1'b1; req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h1234;
        #1;
        chk("flush_ready_low", req_ready[0], 1'b0);
        issue(0, 0, 16'h1234, 16'h0, 16'h1002, 1'b0, 0, 1'b1);
        wait_rsp(0, target);
        chk("miss_cnt_after_flush", miss_cnt[0], 16'd8);

        // Reset in the middle of a fill.
        @(negedge clk); flush[0] = 1'b1;
        @(negedge clk); flush[0] = 1'b0;
        b0 = beat_cnt[0];
        issue(0, 0, 16'h1234, 16'h0, 16'h0, 1'b0, 0, 1'b0);
        n = 0;
        while (beat_cnt[0] < b0 + 3 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("beats_before_reset", beat_cnt[0] - b0, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("outputs_in_reset dut0", outv(0), RST_OUT);
        chk("outputs_in_reset dut1", outv(1), RST_OUT);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        r0 = rsp_cnt[0];
        stray[0] = 3;
        repeat (6) @(negedge clk);
        #1;
        chk("stray_beats_ignored", {hit_cnt[0], miss_cnt[0], 16'(rsp_cnt[0] - r0)}, 48'd0);
        b0 = beat_cnt[0];
        do_req(0, 0, 16'h1234, 16'h0, 16'h1002, 1'b0, 0);
        chk("refetch_beats", beat_cnt[0] - b0, 8);
        chk("counts_after_reset", {hit_cnt[0], miss_cnt[0]}, {16'd0, 16'd1});

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb0.size() + sb1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
